// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: per-state strobe decode, memory wait/timeout handling, retired count.
// Outputs decode combinationally from state; IF/MEM stall on mem_ready (handshake) or a fixed latency.
module multicycle_control #(
  parameter int MEM_MODE = 1,
  parameter int MEM_LAT  = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic        is_x17_ten,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic [1:0]  wb_sel,
  output logic        is_halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_retired;

  state_t      w_next;
  logic        w_done;
  logic        w_timeout;
  logic        w_legal;
  logic        w_mem_req, w_mem_we, w_i_or_d, w_ir_write, w_reg_write, w_pc_write;
  logic [1:0]  w_pc_source, w_wb_sel;
  logic        w_is_halted, w_err;

  assign w_done    = (MEM_MODE != 0) ? mem_ready : (r_cnt == 8'(MEM_LAT - 1));
  // mem_ready in the final allowed cycle still counts as completion
  assign w_timeout = (MEM_MODE != 0) && !mem_ready && (r_cnt == 8'(TIMEOUT - 1));
  assign w_legal   = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_ECALL};

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_i_or_d    = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_source = 2'b00;
    w_wb_sel    = 2'b00;
    w_is_halted = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IF: begin
        w_mem_req = 1'b1;
        if (w_done) begin
          w_ir_write = 1'b1;
          w_next     = S_ID;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_ID: begin
        if (opcode == OP_ECALL) begin
          if (is_x17_ten) begin
            w_next = S_HALT;
          end else begin
            w_pc_write = 1'b1;
            w_next     = S_IF;
          end
        end else if (!w_legal) begin
          w_next = S_ERR;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I:        w_next = S_WB;
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_BR: begin
            w_pc_write  = 1'b1;
            w_pc_source = bcond ? 2'b01 : 2'b00;
            w_next      = S_IF;
          end
          OP_JAL: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b01;
            w_reg_write = 1'b1;
            w_wb_sel    = 2'b10;
            w_next      = S_IF;
          end
          OP_JALR: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b10;
            w_reg_write = 1'b1;
            w_wb_sel    = 2'b10;
            w_next      = S_IF;
          end
          default: w_next = S_ERR;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        w_mem_we  = (opcode == OP_STORE);
        if (w_done) begin
          if (opcode == OP_STORE) begin
            w_pc_write = 1'b1;
            w_next     = S_IF;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        w_pc_write  = 1'b1;
        w_next      = S_IF;
      end
      S_HALT: w_is_halted = 1'b1;
      S_ERR: begin
        w_is_halted = 1'b1;
        w_err       = 1'b1;
      end
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IF;
      r_cnt     <= 8'd0;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_IF || r_state == S_MEM) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_pc_write || (r_state == S_ID && w_next == S_HALT)) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // IF is the reset state, so its memory request must be masked while reset is held
  assign mem_req   = w_mem_req   & ~reset;
  assign mem_we    = w_mem_we    & ~reset;
  assign i_or_d    = w_i_or_d    & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign pc_write  = w_pc_write  & ~reset;
  assign pc_source = w_pc_source & {2{~reset}};
  assign wb_sel    = w_wb_sel    & {2{~reset}};
  assign is_halted = w_is_halted & ~reset;
  assign err       = w_err       & ~reset;
  assign state     = r_state;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a fixed-latency instance and a handshake instance share stimulus;
// an instruction-level trace model supplies expected per-cycle outputs for the selected instance.
module tb_multicycle_control;

  localparam int LAT = 2;
  localparam int TO  = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_EC  = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] opcode;
  logic       bcond, is_x17_ten, mem_ready;

  logic a_mem_req, a_mem_we, a_i_or_d, a_ir_write, a_reg_write, a_pc_write, a_is_halted, a_err;
  logic b_mem_req, b_mem_we, b_i_or_d, b_ir_write, b_reg_write, b_pc_write, b_is_halted, b_err;
  logic [1:0]  a_pc_source, a_wb_sel, b_pc_source, b_wb_sel;
  logic [2:0]  a_state, b_state;
  logic [31:0] a_retired, b_retired;

  multicycle_control #(.MEM_MODE(0), .MEM_LAT(LAT), .TIMEOUT(16)) dut_fixed (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .is_x17_ten(is_x17_ten),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we), .i_or_d(a_i_or_d),
    .ir_write(a_ir_write), .reg_write(a_reg_write), .pc_write(a_pc_write),
    .pc_source(a_pc_source), .wb_sel(a_wb_sel), .is_halted(a_is_halted), .err(a_err),
    .state(a_state), .retired(a_retired));

  multicycle_control #(.MEM_MODE(1), .MEM_LAT(LAT), .TIMEOUT(TO)) dut_hs (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .is_x17_ten(is_x17_ten),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we), .i_or_d(b_i_or_d),
    .ir_write(b_ir_write), .reg_write(b_reg_write), .pc_write(b_pc_write),
    .pc_source(b_pc_source), .wb_sel(b_wb_sel), .is_halted(b_is_halted), .err(b_err),
    .state(b_state), .retired(b_retired));

  logic [14:0] a_vec, b_vec, obs_vec;
  logic [31:0] obs_ret;
  logic        sel;
  assign a_vec = {a_state, a_mem_req, a_mem_we, a_i_or_d, a_ir_write, a_reg_write, a_pc_write,
                  a_pc_source, a_wb_sel, a_is_halted, a_err};
  assign b_vec = {b_state, b_mem_req, b_mem_we, b_i_or_d, b_ir_write, b_reg_write, b_pc_write,
                  b_pc_source, b_wb_sel, b_is_halted, b_err};
  assign obs_vec = sel ? b_vec : a_vec;
  assign obs_ret = sel ? b_retired : a_retired;

  typedef struct {
    logic [14:0] v;
    logic [31:0] ret;
    logic        rdy;
    logic [6:0]  op;
    logic        bc;
    logic        x17;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_ret;
  logic [6:0]  cur_op;
  logic        cur_bc, cur_x17;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  function automatic logic [14:0] mk(input int st, input bit mq, we, iod, irw, rw, pw,
                                     input int src, wb, input bit h, e);
    return {3'(st), mq, we, iod, irw, rw, pw, 2'(src), 2'(wb), h, e};
  endfunction

  function automatic logic rany();
    return 1'($urandom % 2);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_B, OP_JAL, OP_JR, OP_EC};
  endfunction

  task automatic push(input logic [14:0] v, input logic rdy, input bit inc);
    exp_t e;
    e.v = v; e.ret = m_ret; e.rdy = rdy; e.op = cur_op; e.bc = cur_bc; e.x17 = cur_x17;
    exp_q.push_back(e);
    if (inc) m_ret = m_ret + 32'd1;
  endtask

  // Non-completing cycles of a memory access; d = cycles mem_ready stays low in handshake mode
  task automatic stall(input int st, input bit we, input int d, output bit ok);
    int n;
    if (sel) begin
      ok = (d < TO);
      n  = ok ? d : TO;
    end else begin
      ok = 1'b1;
      n  = LAT - 1;
    end
    for (int k = 0; k < n; k++)
      push(mk(st, 1, we, st == 3, 0, 0, 0, 0, 0, 0, 0), sel ? 1'b0 : rany(), 0);
  endtask

  task automatic terminal(input int st);
    for (int k = 0; k < 3; k++) push(mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 1, st == 6), rany(), 0);
  endtask

  task automatic build(input logic [6:0] op, input bit bc, x17, input int d_if, d_mem,
                       output bit term);
    bit ok;
    term = 1'b0; cur_op = op; cur_bc = bc; cur_x17 = x17;
    stall(0, 0, d_if, ok);
    if (!ok) begin terminal(6); term = 1'b1; return; end
    push(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), sel ? 1'b1 : rany(), 0);
    if (op == OP_EC) begin
      if (x17) begin
        push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rany(), 1);
        terminal(5); term = 1'b1;
      end else begin
        push(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), rany(), 1);
      end
      return;
    end
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rany(), 0);
    if (!is_legal(op)) begin terminal(6); term = 1'b1; return; end
    case (op)
      OP_B:   push(mk(2, 0, 0, 0, 0, 0, 1, bc ? 1 : 0, 0, 0, 0), rany(), 1);
      OP_JAL: push(mk(2, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0), rany(), 1);
      OP_JR:  push(mk(2, 0, 0, 0, 0, 1, 1, 2, 2, 0, 0), rany(), 1);
      default: begin
        push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rany(), 0);
        if (op == OP_LD || op == OP_ST) begin
          stall(3, op == OP_ST, d_mem, ok);
          if (!ok) begin terminal(6); term = 1'b1; return; end
          push(mk(3, 1, op == OP_ST, 1, 0, 0, op == OP_ST, 0, 0, 0, 0), sel ? 1'b1 : rany(),
               op == OP_ST);
          if (op == OP_ST) return;
        end
        push(mk(4, 0, 0, 0, 0, 1, 1, 0, op == OP_LD ? 1 : 0, 0, 0), rany(), 1);
      end
    endcase
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_ret = 32'd0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input exp_t e);
    opcode = e.op; bcond = e.bc; is_x17_ten = e.x17; mem_ready = e.rdy;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    bit   t;
    sel = 1'b1;
    reset = 1'b1; opcode = OP_R; bcond = 0; is_x17_ten = 0; mem_ready = 0;
    #1;
    n_checks++;
    if (b_vec !== 15'd0 || b_retired !== 32'd0) begin
      n_fail++; $display("FAIL reset_hs outputs got %b/%0d expected 0/0", b_vec, b_retired);
    end
    n_checks++;
    if (a_vec !== 15'd0 || a_retired !== 32'd0) begin
      n_fail++; $display("FAIL reset_fixed outputs got %b/%0d expected 0/0", a_vec, a_retired);
    end
    apply_reset();
    build(OP_R, 0, 0, 1, 0, t);
    build(OP_LD, 0, 0, 0, 3, t);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      drive(e);
      n_checks++;
      if (obs_vec !== e.v || obs_ret !== e.ret) begin
        n_fail++; $display("FAIL reset_pre cyc%0d got %b/%0d expected %b/%0d", cyc, obs_vec, obs_ret, e.v, e.ret);
      end
      if (e.v[14:12] == 3'd3) break;
      cyc++; @(negedge clk);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_vec !== 15'd0 || obs_ret !== 32'd0) begin
      n_fail++; $display("FAIL reset_abort got %b/%0d expected 0/0", obs_vec, obs_ret);
    end
    exp_q.delete(); m_ret = 32'd0;
    @(negedge clk); reset = 1'b0;
    build(OP_I, 0, 0, 2, 0, t);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); drive(e);
      n_checks++;
      if (obs_vec !== e.v || obs_ret !== e.ret) begin
        n_fail++; $display("FAIL reset_fresh cyc%0d got %b/%0d expected %b/%0d", cyc, obs_vec, obs_ret, e.v, e.ret);
      end
      cyc++; @(negedge clk);
    end
  endtask

  task automatic test_scenario(input string name, input bit s, input logic [6:0] op,
                               input bit bc, x17, input int d_if, d_mem);
    exp_t e;
    bit   t;
    sel = s;
    apply_reset();
    if (op == OP_EC) build(OP_R, 0, 0, 0, 0, t);
    build(op, bc, x17, d_if, d_mem, t);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); drive(e);
      n_checks++;
      if (obs_vec !== e.v) begin
        n_fail++; $display("FAIL %s cyc%0d outputs got %b expected %b", name, cyc, obs_vec, e.v);
      end
      n_checks++;
      if (obs_ret !== e.ret) begin
        n_fail++; $display("FAIL %s cyc%0d retired got %0d expected %0d", name, cyc, obs_ret, e.ret);
      end
      cyc++; @(negedge clk);
    end
  endtask

  task automatic test_fixed_rtype();
    test_scenario("fixed_rtype", 0, OP_R, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (a_retired !== 32'd1 || a_state !== 3'd0) begin
      n_fail++; $display("FAIL fixed_rtype_end got ret=%0d st=%0d expected 1/0", a_retired, a_state);
    end
  endtask

  task automatic test_illegal_reset();
    test_scenario("illegal", 1, OP_R, 0, 0, 0, 0);
    test_scenario("illegal", 1, 7'b0000000, 0, 0, 1, 0);
    // retired is 0 here; run an R first in the same reset epoch to make the clear visible
    sel = 1'b1;
    begin
      bit   t;
      exp_t e;
      apply_reset();
      build(OP_R, 0, 0, 0, 0, t);
      build(7'b0000000, 0, 0, 0, 0, t);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); drive(e);
        n_checks++;
        if (obs_vec !== e.v || obs_ret !== e.ret) begin
          n_fail++; $display("FAIL illegal_seq cyc%0d got %b/%0d expected %b/%0d", cyc, obs_vec, obs_ret, e.v, e.ret);
        end
        cyc++; @(negedge clk);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (b_state !== 3'd0 || b_err !== 1'b0 || b_is_halted !== 1'b0 || b_retired !== 32'd0) begin
      n_fail++; $display("FAIL err_reset got st=%0d err=%b ret=%0d expected 0/0/0", b_state, b_err, b_retired);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] ops[8] = '{OP_R, OP_I, OP_LD, OP_ST, OP_B, OP_JAL, OP_JR, OP_EC};
    logic [6:0] op;
    exp_t e;
    bit   t;
    int   d_if, d_mem;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      apply_reset();
      for (int i = 0; i < 150; i++) begin
        op = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 19) == 0) begin
          op = 7'($urandom);
          if (is_legal(op)) op = 7'h7f;
        end
        d_if  = ($urandom_range(0, 24) == 0) ? 7 : $urandom_range(0, 3);
        d_mem = ($urandom_range(0, 24) == 0) ? 7 : $urandom_range(0, 3);
        build(op, rany(), $urandom_range(0, 5) == 0, d_if, d_mem, t);
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front(); drive(e);
          n_checks++;
          if (obs_vec !== e.v || obs_ret !== e.ret) begin
            n_fail++; $display("FAIL random m%0d op=%b cyc%0d got %b/%0d expected %b/%0d", s, op, cyc, obs_vec, obs_ret, e.v, e.ret);
          end
          cyc++; @(negedge clk);
        end
        if (t) apply_reset();
      end
    end
  endtask

  initial begin
    m_ret = 32'd0;
    test_reset();
    test_fixed_rtype();
    test_scenario("load_hs", 1, OP_LD, 0, 0, 0, 3);
    test_scenario("store_fixed", 0, OP_ST, 0, 0, 0, 0);
    test_scenario("branch_taken", 1, OP_B, 1, 0, 1, 0);
    test_scenario("branch_not", 1, OP_B, 0, 0, 0, 0);
    test_scenario("jal", 1, OP_JAL, 0, 0, 2, 0);
    test_scenario("jalr", 0, OP_JR, 0, 0, 0, 0);
    test_scenario("ecall_halt", 1, OP_EC, 0, 1, 0, 0);
    test_scenario("ecall_cont", 0, OP_EC, 0, 0, 0, 0);
    test_scenario("timeout_if", 1, OP_R, 0, 0, 9, 0);
    test_scenario("ready_last", 1, OP_R, 0, 0, 3, 0);
    test_scenario("timeout_mem", 1, OP_ST, 0, 0, 0, 9);
    test_illegal_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
